// File: rtl/mem_access_unit_pkg.sv
// Access-size encodings and helpers shared by the data-RAM load/store path.
// The size encodings are also used by the cache fill path.
package mem_access_unit_pkg;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

    // Illegal size 3 maps to 4 bytes; it is rejected before this value matters.
    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        case (size)
            MEM_SIZE_BYTE: size_nbytes = 3'd1;
            MEM_SIZE_HALF: size_nbytes = 3'd2;
            default:       size_nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Load formatter: picks byte/half/word from a little-endian RAM word and extends it.
// Purely combinational, zero latency, no flow control.
module load_align
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] result_o
);

    always_comb begin
        result_o = rdata_i;
        case (size_i)
            MEM_SIZE_BYTE: result_o = {{(XLEN-8){~unsigned_i & rdata_i[7]}},   rdata_i[7:0]};
            MEM_SIZE_HALF: result_o = {{(XLEN-16){~unsigned_i & rdata_i[15]}}, rdata_i[15:0]};
            default:       result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-RAM initiator: one load/store at a time, loads respond 3 cycles after accept,
// stores write 1/2/4 bytes serially then respond; req_ready is high only in IDLE.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MEM_BYTES = 65536
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] ram_addr,
    input  logic [XLEN-1:0] ram_rdata,
    output logic            ram_write_en,
    output logic [XLEN-1:0] ram_write_addr,
    output logic [XLEN-1:0] ram_write_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_ISSUE,
        S_LD_CAPTURE,
        S_ST_BYTE,
        S_RESP,
        S_ERR
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [1:0]      size_q;
    logic            unsigned_q;
    logic            write_q;
    logic [1:0]      cnt_q;
    logic            resp_valid_q;
    logic            resp_err_q;
    logic [XLEN-1:0] resp_rdata_q;
    logic [XLEN-1:0] ram_addr_q;
    logic            ram_write_en_q;
    logic [XLEN-1:0] ram_write_addr_q;
    logic [XLEN-1:0] ram_write_data_q;

    logic [XLEN:0]   req_end_d;
    logic            req_bad_d;
    logic            st_last_d;
    logic [1:0]      cnt_d;
    logic [7:0]      wr_byte_d;
    logic [XLEN-1:0] ld_data_d;
    logic [XLEN-1:0] resp_data_d;

    // One extra bit so an address near the top of XLEN cannot wrap past the check.
    assign req_end_d = {1'b0, req_addr} + (XLEN+1)'(size_nbytes(req_size));
    assign req_bad_d = (req_size == 2'd3) || (req_end_d > (XLEN+1)'(MEM_BYTES));
    assign st_last_d = ({1'b0, cnt_q} == (size_nbytes(size_q) - 3'd1));
    assign cnt_d     = cnt_q + 2'd1;

    always_comb begin
        wr_byte_d = wdata_q[7:0];
        case (cnt_d)
            2'd1:    wr_byte_d = wdata_q[15:8];
            2'd2:    wr_byte_d = wdata_q[23:16];
            2'd3:    wr_byte_d = wdata_q[31:24];
            default: wr_byte_d = wdata_q[7:0];
        endcase
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata_i    (ram_rdata),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .result_o   (ld_data_d)
    );

    assign resp_data_d = write_q ? '0 : ld_data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            addr_q           <= '0;
            wdata_q          <= '0;
            size_q           <= '0;
            unsigned_q       <= 1'b0;
            write_q          <= 1'b0;
            cnt_q            <= '0;
            resp_valid_q     <= 1'b0;
            resp_err_q       <= 1'b0;
            resp_rdata_q     <= '0;
            ram_addr_q       <= '0;
            ram_write_en_q   <= 1'b0;
            ram_write_addr_q <= '0;
            ram_write_data_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        write_q    <= req_write;
                        cnt_q      <= '0;
                        ram_addr_q <= req_addr;
                        resp_err_q <= 1'b0;
                        if (req_bad_d) begin
                            state_q      <= S_ERR;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (req_write) begin
                            state_q          <= S_ST_BYTE;
                            ram_write_en_q   <= 1'b1;
                            ram_write_addr_q <= req_addr;
                            ram_write_data_q <= {{(XLEN-8){1'b0}}, req_wdata[7:0]};
                        end else begin
                            state_q <= S_LD_ISSUE;
                        end
                    end
                end
                S_LD_ISSUE: state_q <= S_LD_CAPTURE;
                S_LD_CAPTURE: begin
                    resp_rdata_q <= resp_data_d;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_ST_BYTE: begin
                    if (st_last_d) begin
                        ram_write_en_q <= 1'b0;
                        resp_rdata_q   <= resp_data_d;
                        resp_valid_q   <= 1'b1;
                        state_q        <= S_RESP;
                    end else begin
                        cnt_q            <= cnt_d;
                        ram_write_addr_q <= addr_q + XLEN'(cnt_d);
                        ram_write_data_q <= {{(XLEN-8){1'b0}}, wr_byte_d};
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                S_ERR:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready      = (state_q == S_IDLE);
    assign resp_valid     = resp_valid_q;
    assign resp_err       = resp_err_q;
    assign resp_rdata     = resp_rdata_q;
    assign ram_addr       = ram_addr_q;
    assign ram_write_en   = ram_write_en_q;
    assign ram_write_addr = ram_write_addr_q;
    assign ram_write_data = ram_write_data_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator/master for the byte-array data RAM: it drives that RAM's read address and write port on behalf of the core's load/store stage.
- Accepts one load/store request at a time via valid/ready and returns one response pulse.
- Loads: one registered 4-byte RAM read, then byte/half/word extraction with sign or zero extension.
- Stores: the RAM writes one byte per write cycle, so stores are serialised as 1, 2 or 4 consecutive byte writes.

Parameters:
- XLEN, 32, data/address width (matches `XLEN_WIDTH).
- MEM_BYTES, 65536, RAM depth in bytes; accesses beyond it are rejected.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_write  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0
- req_addr  in  XLEN  byte address (no alignment requirement)
- req_wdata  in  XLEN  store data; low bytes used
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  XLEN  load result; 0 for stores and errors
- resp_err  out  1  valid with resp_valid; illegal size or out-of-range access
- ram_addr  out  XLEN  RAM read address (RAM data out registered, 1-cycle latency)
- ram_rdata  in  XLEN  RAM read data {b[a+3],b[a+2],b[a+1],b[a]}
- ram_write_en  out  1  RAM byte write enable
- ram_write_addr  out  XLEN  RAM write byte address
- ram_write_data  out  XLEN  {24'b0, byte}

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high. rst sampled high at an edge puts the unit in IDLE, clears all registers and returns every output to its reset value:
  - req_ready=1 (IDLE)
  - resp_valid=0, resp_rdata=0, resp_err=0
  - ram_write_en=0, ram_addr=0, ram_write_addr=0, ram_write_data=0
- Reset mid-store: the store aborts; bytes already written stay written; no response is issued.
- Handshake: a request is accepted at a rising edge where req_valid && req_ready. All request fields are captured into addr_q, wdata_q, size_q, unsigned_q and write_q. req_ready is low in every state except IDLE.
- Error check at accept:
  - size==3, or addr+nbytes > MEM_BYTES (nbytes = 1/2/4) -> ERR.
  - No RAM access occurs; in ERR, resp_valid=1, resp_err=1, resp_rdata=0, then IDLE.
- States: IDLE, LD_ISSUE, LD_CAPTURE, ST_BYTE, RESP, ERR.
- Load path:
  - LD_ISSUE: ram_addr=addr_q; the RAM registers data at the edge.
  - LD_CAPTURE: ram_rdata is valid. Format it:
    - byte: rdata[7:0]; half: rdata[15:0]; word: all 32 bits.
    - Extend to 32 bits with bit 7 or bit 15 when !unsigned_q, else with zeros.
    - Register the result into resp_rdata.
  - RESP: resp_valid=1, resp_err=0, for one cycle, then IDLE.
  - Latency: resp_valid is high in the 3rd cycle after the accept edge.
- Store path:
  - ST_BYTE uses a 2-bit counter cnt starting at 0.
  - Each cycle: ram_write_en=1, ram_write_addr=addr_q+cnt, ram_write_data={24'b0, wdata_q[8*cnt+7:8*cnt]}.
  - cnt increments each cycle; after cnt==nbytes-1 go to RESP with resp_rdata=0.
  - Word store: 4 write cycles plus 1 response cycle.
- Write enable is never asserted outside ST_BYTE.
- ram_addr holds addr_q in every state other than IDLE; in IDLE it holds its last value.
- Back-to-back:
  - A new request can be accepted in the cycle after RESP, so the minimum load issue interval is 4 cycles.
  - A load following a store to the same address reads the new data, because the last byte write completes before the load's LD_ISSUE edge.
- Misaligned accesses are legal; byte order is little-endian.
- resp_rdata holds its value between responses; resp_err is cleared on the next accept.

Decomposition:
- Shared const include gets the access-size encodings: MEM_SIZE_BYTE=2'd0, MEM_SIZE_HALF=2'd1, MEM_SIZE_WORD=2'd2.
- State encodings stay local to the module.
- One combinational sub-module, load_align: inputs rdata, size, unsigned; output the extended result. It is reused later by the cache fill path.

Test Plan:
- Load word: RAM bytes 0x100..0x103 = 11 22 33 84; load w @0x100 -> resp_rdata=0x84332211, resp_valid in 3rd cycle after accept, resp_err=0.
- Load byte sign/zero extension: same data, lb @0x103 -> 0xFFFFFF84; lbu @0x103 -> 0x00000084; lh @0x102 -> 0xFFFF8433.
- Store half: sh @0x201, wdata=0xDEADBEEF -> exactly 2 write cycles (0x201<-0xEF, 0x202<-0xBE), then resp_valid with rdata=0; a following lw @0x200 returns bytes 0xBE,0xEF in positions [23:8].
- Errors:
  - req_size=3 -> resp_err=1, resp_rdata=0, no ram_write_en.
  - lw @0xFFFE (MEM_BYTES=65536) -> resp_err=1, no RAM access.
- Reset mid-store: sw @0x300 = 0xAABBCCDD, assert rst after the 2nd write cycle -> next cycle ram_write_en=0, req_ready=1, resp_valid never pulses; bytes 0x300=0xDD and 0x301=0xCC written, 0x302/0x303 unchanged.
- Back-to-back with held valid: req_valid held with 3 queued loads -> exactly one accept per IDLE visit; req_ready low in all other states; 3 resp pulses in order.
